data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the processor's data-memory interface.
- The instruction-cycle block drives address, write data and write enable; this block returns read data combinationally.
- Contains a RAM array in the low address space and a small memory-mapped I/O window: GPIO out, synchronized GPIO in, and a prescaled 8-bit timer with an overflow flag.
- Sits beside the CPU core at top level, one instance per data bus.

Parameters:
- MEM_ADDR_WIDTH, 8, width of mem_addr.
- MEM_DATA_WIDTH, 8, width of the data bus. The MMIO registers are fixed at 8 bits; only 8 is supported.
- MMIO_BASE, 8'hF0, first MMIO address. Addresses from MMIO_BASE to 2^MEM_ADDR_WIDTH-1 form the MMIO window; everything below is RAM.

Ports:
- clk  in  1  system clock, all state on rising edge.
- arst  in  1  reset: synchronous, active-high.
- mem_addr  in  MEM_ADDR_WIDTH  access address, driven by the CPU.
- mem_data_i  in  MEM_DATA_WIDTH  write data from the CPU.
- mem_WE  in  1  write enable, single-cycle pulse from the CPU.
- mem_data_o  out  MEM_DATA_WIDTH  read data to the CPU, combinational from mem_addr.
- gpio_in  in  8  external input pins, asynchronous.
- gpio_out  out  8  registered output port.
- timer_ovf  out  1  timer overflow flag; level output, equals TCTRL[1].

Behaviour:
- Read path
  - mem_data_o = f(mem_addr, current state), zero latency.
  - The CPU samples it at the end of the cycle in which the address is presented.
  - Reads have no side effects.
- Write path
  - Commits on the rising edge where mem_WE=1, using that cycle's mem_addr and mem_data_i.
  - A read of the same address in the next cycle returns the new value.
- RAM
  - Depth MMIO_BASE words, addresses 0 .. MMIO_BASE-1.
  - Contents are NOT cleared by arst and are X until written.
- MMIO map (offset from MMIO_BASE):
  - +0 GPIO_OUT: R/W, drives gpio_out.
  - +1 GPIO_IN: read-only, returns gpio_in through a 2-flop synchronizer (2-cycle latency); writes ignored.
  - +2 TCNT: R/W, timer count; a write loads the count.
  - +3 TCTRL: bit0 EN (R/W); bit1 OVF (read; write-1-to-clear); bits7:2 read 0.
  - +4 TPRE: R/W, prescale reload value.
  - +5 and above: read 0, writes ignored.
- Timer
  - 8-bit prescale counter PC8 runs while EN=1.
  - When PC8==TPRE: PC8 <= 0 and a tick is issued; otherwise PC8 increments.
  - TPRE=0 gives a tick every cycle.
  - On a tick, TCNT increments; the wrap 8'hFF -> 8'h00 sets OVF.
  - EN=0 freezes both PC8 and TCNT.
  - A write to TPRE also clears PC8.
- Simultaneous events
  - CPU write to TCNT in a tick cycle: the write wins, no increment that cycle, OVF unaffected.
  - OVF set by wrap in the same cycle as a W1C write: set wins, OVF stays 1.
- Reset (arst=1 at an edge)
  - gpio_out=0, synchronizer flops=0, TCNT=0, TCTRL=0, TPRE=0, PC8=0, timer_ovf=0.
  - A write with mem_WE=1 in a reset cycle is discarded.
  - Mid-operation reset aborts the prescale phase; RAM is untouched.
- Address wrap: none. Addresses are width-limited, and every code maps to RAM, a register, or reserved.

Optional Feature:
- Macro: DATA_MEM_TIMER_EN.
- Defined: the timer registers (+2..+4) and timer_ovf behave as above.
- Undefined:
  - No timer logic is synthesized.
  - +2..+4 read 0 and writes are ignored.
  - timer_ovf is tied to 0.
  - RAM and GPIO behaviour is unchanged.

Test Plan:
- RAM write/read: write 8'h5A to 8'h10 (mem_WE pulse), present 8'h10 next cycle -> mem_data_o=8'h5A. Write 8'hC3 to 8'hEF -> reads back 8'hC3; 8'h10 still reads 8'h5A.
- GPIO: write 8'hA5 to 8'hF0 -> gpio_out=8'hA5 after the edge, and 8'hF0 reads 8'hA5. Drive gpio_in=8'h3C -> 8'hF1 reads 8'h3C two edges later, old value before that.
- Timer: TPRE=3, TCNT=8'hFE, TCTRL=1 -> TCNT=8'hFF after 4 cycles, 8'h00 after 8 cycles, with timer_ovf=1 on that edge. Write 8'h02 to 8'hF3 -> timer_ovf=0 and EN=0, TCNT frozen.
- Collisions: at the wrap edge, also W1C on TCTRL -> OVF stays 1. At a tick edge, write TCNT=8'h40 -> reads 8'h40, not 8'h41.
- Reserved/reset: 8'hF7 reads 8'h00, and a write to it changes nothing. Assert arst mid-count with gpio_out=8'hFF -> all outputs and registers 0 next cycle; RAM 8'h10 still reads 8'h5A.
- Feature off: build without DATA_MEM_TIMER_EN, write 8'h01 to 8'hF3 and wait 300 cycles -> 8'hF2/8'hF3 read 0, timer_ovf=0.

Source files
------------

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Responder end of the CPU data-memory bus. Low addresses (0 .. MMIO_BASE-1)
// are RAM; MMIO_BASE and above form a small register window:
//   +0 GPIO_OUT  R/W, drives gpio_out
//   +1 GPIO_IN   RO, gpio_in through a 2-flop synchronizer
//   +2 TCNT      R/W timer count            (timer build only)
//   +3 TCTRL     bit0 EN R/W, bit1 OVF W1C  (timer build only)
//   +4 TPRE      R/W prescale reload        (timer build only)
//   +5..         read 0, writes ignored
//
// Optional feature macro: DATA_MEM_TIMER_EN. When undefined no timer logic is
// built, +2..+4 read 0 and timer_ovf is tied low.
//
// Bus protocol: there is no valid/ready handshake. The CPU presents mem_addr
// every cycle and samples mem_data_o (combinational) at the end of that same
// cycle. A write is a single-cycle mem_WE pulse; it commits on the rising edge
// where mem_WE=1 using that cycle's mem_addr/mem_data_i. Reads never have side
// effects.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   arst        synchronous active-high reset (RAM contents are not cleared)
//   mem_addr    access address
//   mem_data_i  write data
//   mem_WE      write enable pulse
//   mem_data_o  read data, combinational from mem_addr and current state
//   gpio_in     asynchronous external inputs
//   gpio_out    registered output port
//   timer_ovf   timer overflow flag (TCTRL bit1)
//
// Only MEM_DATA_WIDTH = 8 is supported; the MMIO registers are 8 bits wide.
// -----------------------------------------------------------------------------
module data_mem_responder #(
   parameter int                        MEM_ADDR_WIDTH = 8,
   parameter int                        MEM_DATA_WIDTH = 8,
   parameter logic [MEM_ADDR_WIDTH-1:0] MMIO_BASE      = 8'hF0
) (
   input  logic                      clk,
   input  logic                      arst,
   input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   input  logic [MEM_DATA_WIDTH-1:0] mem_data_i,
   input  logic                      mem_WE,
   output logic [MEM_DATA_WIDTH-1:0] mem_data_o,
   input  logic [7:0]                gpio_in,
   output logic [7:0]                gpio_out,
   output logic                      timer_ovf
);

   localparam int RAM_DEPTH = int'(MMIO_BASE);

   localparam logic [MEM_ADDR_WIDTH-1:0] OFF_GPIO_OUT = MEM_ADDR_WIDTH'(0);
   localparam logic [MEM_ADDR_WIDTH-1:0] OFF_GPIO_IN  = MEM_ADDR_WIDTH'(1);
   localparam logic [MEM_ADDR_WIDTH-1:0] OFF_TCNT     = MEM_ADDR_WIDTH'(2);
   localparam logic [MEM_ADDR_WIDTH-1:0] OFF_TCTRL    = MEM_ADDR_WIDTH'(3);
   localparam logic [MEM_ADDR_WIDTH-1:0] OFF_TPRE     = MEM_ADDR_WIDTH'(4);

   logic [MEM_DATA_WIDTH-1:0] ram [0:RAM_DEPTH-1];

   logic                      is_mmio;
   logic [MEM_ADDR_WIDTH-1:0] offset;
   logic                      wr_gpio_out;
   logic [MEM_DATA_WIDTH-1:0] gpio_out_q;
   logic [7:0]                sync1;
   logic [7:0]                sync2;

   // Register-side view of the timer; constant zero when the timer is absent.
   logic [MEM_DATA_WIDTH-1:0] tcnt_rd;
   logic [MEM_DATA_WIDTH-1:0] tctrl_rd;
   logic [MEM_DATA_WIDTH-1:0] tpre_rd;
   logic                      ovf_rd;

   assign is_mmio     = (mem_addr >= MMIO_BASE);
   assign offset      = mem_addr - MMIO_BASE;
   assign wr_gpio_out = mem_WE && is_mmio && (offset == OFF_GPIO_OUT);

   // RAM has no reset; a write during reset is still discarded.
   always_ff @(posedge clk) begin
      if (!arst && mem_WE && !is_mmio) begin
         ram[mem_addr] <= mem_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         gpio_out_q <= '0;
         sync1      <= '0;
         sync2      <= '0;
      end else begin
         sync1 <= gpio_in;
         sync2 <= sync1;
         if (wr_gpio_out) begin
            gpio_out_q <= mem_data_i;
         end
      end
   end

`ifdef DATA_MEM_TIMER_EN
   logic       wr_tcnt;
   logic       wr_tctrl;
   logic       wr_tpre;
   logic [7:0] tcnt;
   logic [7:0] tpre;
   logic [7:0] pc8;
   logic       en;
   logic       ovf;
   logic       tick;
   logic       wrap;

   assign wr_tcnt  = mem_WE && is_mmio && (offset == OFF_TCNT);
   assign wr_tctrl = mem_WE && is_mmio && (offset == OFF_TCTRL);
   assign wr_tpre  = mem_WE && is_mmio && (offset == OFF_TPRE);

   assign tick = en && (pc8 == tpre);
   // A CPU load of TCNT suppresses the increment, so it can never wrap.
   assign wrap = tick && !wr_tcnt && (tcnt == 8'hFF);

   always_ff @(posedge clk) begin
      if (arst) begin
         tcnt <= '0;
         tpre <= '0;
         pc8  <= '0;
         en   <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         if (wr_tpre) begin
            tpre <= mem_data_i;
            pc8  <= '0;
         end else if (en) begin
            pc8 <= tick ? 8'h00 : pc8 + 8'h01;
         end

         if (wr_tcnt) begin
            tcnt <= mem_data_i;
         end else if (tick) begin
            tcnt <= tcnt + 8'h01;
         end

         if (wr_tctrl) begin
            en <= mem_data_i[0];
         end

         // Setting by wrap takes priority over a same-cycle write-1-to-clear.
         if (wrap) begin
            ovf <= 1'b1;
         end else if (wr_tctrl && mem_data_i[1]) begin
            ovf <= 1'b0;
         end
      end
   end

   assign tcnt_rd  = tcnt;
   assign tctrl_rd = MEM_DATA_WIDTH'({ovf, en});
   assign tpre_rd  = tpre;
   assign ovf_rd   = ovf;
`else
   assign tcnt_rd  = '0;
   assign tctrl_rd = '0;
   assign tpre_rd  = '0;
   assign ovf_rd   = 1'b0;
`endif

   always_comb begin
      mem_data_o = '0;
      if (!is_mmio) begin
         mem_data_o = ram[mem_addr];
      end else begin
         case (offset)
            OFF_GPIO_OUT: mem_data_o = gpio_out_q;
            OFF_GPIO_IN:  mem_data_o = sync2;
            OFF_TCNT:     mem_data_o = tcnt_rd;
            OFF_TCTRL:    mem_data_o = tctrl_rd;
            OFF_TPRE:     mem_data_o = tpre_rd;
            default:      mem_data_o = '0;
         endcase
      end
   end

   assign gpio_out  = gpio_out_q;
   assign timer_ovf = ovf_rd;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Bench for data_mem_responder. A behavioural model of the memory map is
// updated at every rising edge from the inputs seen at that edge; one compare
// process checks read data, gpio_out and timer_ovf against it on every falling
// edge. Directed sequences add hand-computed literal expectations, then a
// randomized phase runs with occasional resets. Timer checks follow the
// DATA_MEM_TIMER_EN macro, exactly as the design does.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

   localparam logic [7:0] BASE    = 8'hF0;
   localparam logic [7:0] A_GPO   = 8'hF0;
   localparam logic [7:0] A_GPI   = 8'hF1;
   localparam logic [7:0] A_TCNT  = 8'hF2;
   localparam logic [7:0] A_TCTRL = 8'hF3;
   localparam logic [7:0] A_TPRE  = 8'hF4;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       arst = 1'b1;
   logic [7:0] mem_addr = A_GPI;
   logic [7:0] mem_data_i = 8'h00;
   logic       mem_WE = 1'b0;
   logic [7:0] gpio_in = 8'h77;
   logic [7:0] mem_data_o;
   logic [7:0] gpio_out;
   logic       timer_ovf;

   always #5 clk = ~clk;

   data_mem_responder #(
      .MEM_ADDR_WIDTH(8),
      .MEM_DATA_WIDTH(8),
      .MMIO_BASE(8'hF0)
   ) dut (
      .clk(clk),
      .arst(arst),
      .mem_addr(mem_addr),
      .mem_data_i(mem_data_i),
      .mem_WE(mem_WE),
      .mem_data_o(mem_data_o),
      .gpio_in(gpio_in),
      .gpio_out(gpio_out),
      .timer_ovf(timer_ovf)
   );

   // ---------------- scoreboard bookkeeping ----------------
   int         checks = 0;
   int         errors = 0;
   bit         cmp_en = 1'b0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (addr %h, t=%0t)", name, act, exp, mem_addr, $time);
      end
   endtask

   // Literal expectation: queued, then popped against the sampled value.
   task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
      exp_q.push_back(exp);
      check(name, act, exp_q.pop_front());
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0] m_ram [0:239];
   bit         m_vld [0:239];
   logic [7:0] m_gpio_out;
   logic [7:0] m_s1, m_s2;
   logic [7:0] m_tcnt, m_tpre, m_pc;
   logic       m_en, m_ovf;

   initial begin
      for (int i = 0; i < 240; i++) m_vld[i] = 1'b0;
   end

   always @(posedge clk) begin
      logic tick;
      logic wrap;
      if (arst) begin
         m_gpio_out = 8'h00;
         m_s1 = 8'h00;
         m_s2 = 8'h00;
         m_tcnt = 8'h00;
         m_tpre = 8'h00;
         m_pc = 8'h00;
         m_en = 1'b0;
         m_ovf = 1'b0;
      end else begin
         // GPIO_IN shows the value gpio_in had two edges earlier.
         m_s2 = m_s1;
         m_s1 = gpio_in;
         if (mem_WE && mem_addr < BASE) begin
            m_ram[mem_addr] = mem_data_i;
            m_vld[mem_addr] = 1'b1;
         end
         if (mem_WE && mem_addr == A_GPO) m_gpio_out = mem_data_i;
`ifdef DATA_MEM_TIMER_EN
         tick = m_en && (m_pc == m_tpre);
         wrap = 1'b0;
         if (m_en) m_pc = tick ? 8'h00 : 8'(m_pc + 8'h01);
         if (mem_WE && mem_addr == A_TPRE) begin
            m_tpre = mem_data_i;
            m_pc = 8'h00;
         end
         if (mem_WE && mem_addr == A_TCNT) begin
            m_tcnt = mem_data_i;
         end else if (tick) begin
            wrap = (m_tcnt == 8'hFF);
            m_tcnt = 8'(m_tcnt + 8'h01);
         end
         if (mem_WE && mem_addr == A_TCTRL) begin
            m_en = mem_data_i[0];
            if (mem_data_i[1]) m_ovf = 1'b0;
         end
         if (wrap) m_ovf = 1'b1;
`else
         tick = 1'b0;
         wrap = 1'b0;
`endif
      end
   end

   function automatic logic [7:0] model_read(input logic [7:0] a);
      if (a < BASE) return m_ram[a];
      case (a)
         A_GPO:   return m_gpio_out;
         A_GPI:   return m_s2;
`ifdef DATA_MEM_TIMER_EN
         A_TCNT:  return m_tcnt;
         A_TCTRL: return {6'b0, m_ovf, m_en};
         A_TPRE:  return m_tpre;
`endif
         default: return 8'h00;
      endcase
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         if (mem_addr >= BASE || m_vld[mem_addr]) begin
            check("rdata", mem_data_o, model_read(mem_addr));
         end
         check("gpio_out", gpio_out, m_gpio_out);
         check("timer_ovf", {7'b0, timer_ovf}, {7'b0, m_ovf});
      end
   end

   // ---------------- driver ----------------
   task automatic step(input logic [7:0] a, input logic [7:0] d, input logic we, input logic rst);
      @(posedge clk);
      #2;
      mem_addr   = a;
      mem_data_i = d;
      mem_WE     = we;
      arst       = rst;
   endtask

   task automatic rd(input logic [7:0] a);
      step(a, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      step(a, d, 1'b1, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] a;
      logic [7:0] d;

      // Reset state: synchronizer is cleared even though gpio_in is nonzero.
      @(posedge clk);
      #2;
      cmp_en = 1'b1;
      @(negedge clk);
      lit("reset_gpio_in", mem_data_o, 8'h00);
      lit("reset_gpio_out", gpio_out, 8'h00);
      lit("reset_ovf", {7'b0, timer_ovf}, 8'h00);
      step(A_TCNT, 8'h00, 1'b0, 1'b1);
      @(negedge clk);
      lit("reset_tcnt", mem_data_o, 8'h00);
      step(A_TCTRL, 8'h00, 1'b0, 1'b1);
      @(negedge clk);
      lit("reset_tctrl", mem_data_o, 8'h00);

      // Synchronizer latency out of reset, then 3C arriving two edges later.
      rd(A_GPI);
      @(negedge clk);
      lit("sync_first", mem_data_o, 8'h00);
      rd(A_GPI);
      rd(A_GPI);
      @(negedge clk);
      lit("sync_77", mem_data_o, 8'h77);
      rd(A_GPI);
      gpio_in = 8'h3C;
      @(negedge clk);
      lit("sync_old0", mem_data_o, 8'h77);
      rd(A_GPI);
      @(negedge clk);
      lit("sync_old1", mem_data_o, 8'h77);
      rd(A_GPI);
      @(negedge clk);
      lit("sync_new", mem_data_o, 8'h3C);
      wr(A_GPI, 8'h12);
      rd(A_GPI);
      @(negedge clk);
      lit("gpio_in_ro", mem_data_o, 8'h3C);

      // RAM write/read.
      wr(8'h10, 8'h5A);
      rd(8'h10);
      @(negedge clk);
      lit("ram_10", mem_data_o, 8'h5A);
      wr(8'hEF, 8'hC3);
      rd(8'hEF);
      @(negedge clk);
      lit("ram_ef", mem_data_o, 8'hC3);
      rd(8'h10);
      @(negedge clk);
      lit("ram_10_kept", mem_data_o, 8'h5A);

      // GPIO out.
      wr(A_GPO, 8'hA5);
      rd(A_GPO);
      @(negedge clk);
      lit("gpio_out_pin", gpio_out, 8'hA5);
      lit("gpio_out_rd", mem_data_o, 8'hA5);

      // Reserved address.
      rd(8'hF7);
      @(negedge clk);
      lit("rsvd_rd", mem_data_o, 8'h00);
      wr(8'hF7, 8'hFF);
      rd(8'hF7);
      @(negedge clk);
      lit("rsvd_after_wr", mem_data_o, 8'h00);
      lit("rsvd_gpio", gpio_out, 8'hA5);

`ifdef DATA_MEM_TIMER_EN
      // Prescale 3 from FE: FF four edges after enable, 00 plus OVF at eight.
      wr(A_TPRE, 8'h03);
      wr(A_TCNT, 8'hFE);
      wr(A_TCTRL, 8'h01);
      for (int i = 0; i < 5; i++) rd(A_TCNT);
      @(negedge clk);
      lit("tmr_ff", mem_data_o, 8'hFF);
      for (int i = 0; i < 4; i++) rd(A_TCNT);
      @(negedge clk);
      lit("tmr_wrap", mem_data_o, 8'h00);
      lit("tmr_ovf", {7'b0, timer_ovf}, 8'h01);
      wr(A_TCTRL, 8'h02);
      rd(A_TCTRL);
      @(negedge clk);
      lit("tmr_w1c", mem_data_o, 8'h00);
      lit("tmr_w1c_pin", {7'b0, timer_ovf}, 8'h00);
      for (int i = 0; i < 6; i++) rd(A_TCNT);
      @(negedge clk);
      lit("tmr_frozen", mem_data_o, 8'h00);

      // Wrap and W1C in the same cycle: set wins.
      wr(A_TPRE, 8'h00);
      wr(A_TCNT, 8'hFF);
      wr(A_TCTRL, 8'h01);
      wr(A_TCTRL, 8'h03);
      rd(A_TCTRL);
      @(negedge clk);
      lit("coll_ovf", {7'b0, timer_ovf}, 8'h01);
      lit("coll_tctrl", mem_data_o, 8'h03);
      // TCNT load on a tick edge: load wins.
      wr(A_TCNT, 8'h40);
      rd(A_TCNT);
      @(negedge clk);
      lit("coll_tcnt", mem_data_o, 8'h40);
`else
      // Timer absent: registers read 0, ovf stays low however long we wait.
      wr(A_TCTRL, 8'h01);
      wr(A_TPRE, 8'h01);
      wr(A_TCNT, 8'h33);
      for (int i = 0; i < 300; i++) rd(A_TCNT);
      @(negedge clk);
      lit("off_tcnt", mem_data_o, 8'h00);
      rd(A_TCTRL);
      @(negedge clk);
      lit("off_tctrl", mem_data_o, 8'h00);
      lit("off_ovf", {7'b0, timer_ovf}, 8'h00);
`endif

      // Mid-operation reset; the RAM write attempted during reset is dropped.
      wr(A_GPO, 8'hFF);
      rd(A_GPO);
      @(negedge clk);
      lit("pre_rst_gpio", gpio_out, 8'hFF);
      step(8'h10, 8'h99, 1'b1, 1'b1);
      rd(A_TCNT);
      @(negedge clk);
      lit("rst_gpio", gpio_out, 8'h00);
      lit("rst_ovf", {7'b0, timer_ovf}, 8'h00);
      lit("rst_tcnt", mem_data_o, 8'h00);
      rd(A_TCTRL);
      @(negedge clk);
      lit("rst_tctrl", mem_data_o, 8'h00);
      rd(A_TPRE);
      @(negedge clk);
      lit("rst_tpre", mem_data_o, 8'h00);
      rd(8'h10);
      @(negedge clk);
      lit("rst_ram", mem_data_o, 8'h5A);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 3))
            0: a = 8'($urandom_range(0, 15));
            1: a = 8'($urandom_range(8'hE8, 8'hEF));
            default: a = 8'($urandom_range(8'hF0, 8'hFF));
         endcase
         d = 8'($urandom_range(0, 255));
         if (a == A_TPRE) d = 8'($urandom_range(0, 3));
         if (a == A_TCNT && $urandom_range(0, 1) == 1) d = 8'hFD;
         gpio_in = 8'($urandom_range(0, 255));
         step(a, d, ($urandom_range(0, 99) < 35), ($urandom_range(0, 199) == 0));
      end

      rd(8'h00);
      @(negedge clk);
      @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
